tt_um_nithin574_sum_rx: RTL and testbench
=========================================

TT_UM_NITHIN574_SUM_RX -- requirements
Module: tt_um_nithin574_sum_rx

Interface
REQ-001 SHALL have a parameter: DEPTH, default 4, meaning the number of FIFO entries (power of two, 2..8).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port ui_in, input, 8 bits: [5:0] known operand A, [6] pop request, [7] status select.
REQ-005 SHALL have port uio_in, input, 8 bits: [6:0] incoming 7-bit sum S, [7] sample strobe; a rising strobe marks a new S.
REQ-006 SHALL have port uo_out, output, 8 bits: the data view or the status view (REQ-016/017).
REQ-007 SHALL have port uio_out, output, 8 bits, tied to 0.
REQ-008 SHALL have port uio_oe, output, 8 bits, tied to 0 (all uio pins are inputs).
REQ-009 SHALL have port ena, input, 1 bit, ignored.

Function
REQ-010 SHALL register uio_in[7:0] and ui_in[6] in one input stage each cycle (strobe_q, S_q, pop_q), plus one delayed copy of each strobe and pop (strobe_qq, pop_qq).
REQ-011 SHALL detect a capture event when strobe_q=1 and strobe_qq=0, i.e. one event per strobe rising edge, regardless of how long strobe stays high.
REQ-012 SHALL detect a pop event when pop_q=1 and pop_qq=0, with a single event per rising edge of ui_in[6].
REQ-013 On a capture event SHALL compute the 8-bit diff = {0,S_q} - {00,ui_in[5:0]} (A is sampled in the same cycle), B = diff[5:0], and err = diff[7] | diff[6].
REQ-014 SHALL push {err,B} into a DEPTH-entry FIFO on the clock edge that follows the capture event; the entry is visible at uo_out after that edge, giving 2 clk of latency from the strobe rising edge.
REQ-015 The FIFO SHALL track occupancy count 0..DEPTH with wrap-around read/write pointers of width log2(DEPTH).
REQ-016 Data view (ui_in[7]=0) SHALL drive uo_out[5:0]=head B, uo_out[6]=head err, and uo_out[7]=(count!=0); when empty, [6:0]=0.
REQ-017 Status view (ui_in[7]=1) SHALL drive uo_out[3:0]=count, [4]=full, [5]=overflow sticky, [6]=err_seen sticky, and [7]=(count!=0).
REQ-018 A pop event with ui_in[7]=0 and count>0 SHALL remove the head; a pop event with count=0 SHALL do nothing.
REQ-019 A pop event with ui_in[7]=1 SHALL clear both the overflow and err_seen sticky bits and SHALL NOT pop.
REQ-020 Push with full and no pop SHALL drop the sample, leave the FIFO unchanged and set overflow.
REQ-021 Simultaneous push and pop SHALL behave as follows:
  - full: both occur, count is unchanged, overflow is not set;
  - empty: push only, count becomes 1;
  - otherwise: both occur, count is unchanged.
REQ-022 err_seen SHALL set on any push whose err=1; if a set and a clear (REQ-019) fall in the same cycle, set wins.
REQ-023 SHALL hold state when there is no event; no other state SHALL change.

Reset
REQ-024 While rst=1 at a clk edge, the following SHALL be cleared:
  - count and both pointers;
  - overflow and err_seen;
  - all input-stage and delay flops.
REQ-025 After reset, uo_out SHALL be 0x00 in the data view and 0x00 in the status view.
REQ-026 Reset asserted mid-operation SHALL discard all stored entries and any capture or pop in flight; the first event after release requires a fresh rising edge.
REQ-027 The strobe or pop held high through reset release SHALL NOT generate an event.

Verification
REQ-028 Single capture: A=10, S=25, strobe 0->1 -> uo_out=0x8F (B=15, err=0, valid) exactly 2 clk after the strobe edge is sampled.
REQ-029 Error case: A=40, S=20 -> B=44, err=1, uo_out=0xEC; the status view then shows err_seen=1.
REQ-030 Fill and overflow: 5 captures with S=1..5, A=0, no pop -> status count=4, full=1, overflow=1; pops yield 1,2,3,4, then valid=0.
REQ-031 Push and pop in the same cycle while full: count stays 4, overflow stays 0, and the head advances correctly.
REQ-032 Strobe held high for 10 clk -> exactly one entry is pushed; pop with status select -> overflow and err_seen return to 0 and count is unchanged.
REQ-033 Reset asserted with 3 entries stored and a strobe high -> count=0 and uo_out=0x00 after release; no push occurs until the next strobe rising edge.

Source files
------------

// File: rtl/tt_um_nithin574_sum_rx.sv
// ----------------------------------------------------------------------------
// tt_um_nithin574_sum_rx
//
// Receives a stream of 7-bit sums S. For each sum, it recovers the unknown
// operand B = S - A, where A is a known 6-bit operand. The result, together
// with an error flag (the difference does not fit in 6 bits), is queued in a
// small FIFO. The head of the FIFO, or a status word, is shown on uo_out.
//
// Ports
//   clk      : clock, all state updates on the rising edge
//   rst      : synchronous, active-high reset
//   ena      : unused
//   ui_in    : [5:0] operand A, [6] pop request, [7] status select
//   uio_in   : [6:0] sum S, [7] sample strobe (a rising edge captures S)
//   uo_out   : data view  {valid, err, B}
//              status view {valid, err_seen, overflow, full, count[3:0]}
//   uio_out  : tied to 0
//   uio_oe   : tied to 0 (all uio pins are inputs)
// ----------------------------------------------------------------------------
module tt_um_nithin574_sum_rx #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   // Builds the FIFO entry {err, B} from the sum and the known operand.
   // The subtraction is done as a signed 8-bit value; any bit set above
   // bit 5 means B is negative or too large for 6 bits.
   function automatic logic [6:0] sum_to_entry(input logic [6:0] s,
                                               input logic [5:0] a);
      logic signed [7:0] diff;
      diff = signed'({1'b0, s}) - signed'({2'b00, a});
      return {diff[7] | diff[6], diff[5:0]};
   endfunction

   logic unused_ena;
   assign unused_ena = ena;

   assign uio_out = 8'h00;
   assign uio_oe  = 8'h00;

   // ---------------- input stage ----------------
   logic       strobe_q, strobe_qq, pop_q, pop_qq;
   logic [6:0] s_q;
   // The arm flops block edge detection until the raw input has been seen
   // low after reset, so a strobe or pop held high through reset release
   // never produces an event.
   logic       strobe_arm_q, pop_arm_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         strobe_q     <= 1'b0;
         strobe_qq    <= 1'b0;
         pop_q        <= 1'b0;
         pop_qq       <= 1'b0;
         s_q          <= '0;
         strobe_arm_q <= 1'b0;
         pop_arm_q    <= 1'b0;
      end else begin
         strobe_q     <= uio_in[7];
         strobe_qq    <= strobe_q;
         s_q          <= uio_in[6:0];
         pop_q        <= ui_in[6];
         pop_qq       <= pop_q;
         strobe_arm_q <= strobe_arm_q | ~uio_in[7];
         pop_arm_q    <= pop_arm_q | ~ui_in[6];
      end
   end

   logic cap_ev, pop_ev;
   assign cap_ev = strobe_q & ~strobe_qq & strobe_arm_q;
   assign pop_ev = pop_q & ~pop_qq & pop_arm_q;

   // ---------------- FIFO control ----------------
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d, err_seen_q, err_seen_d;
   logic [6:0]    mem_q [DEPTH];
   logic [6:0]    entry;
   logic          empty, full, do_push, do_pop, do_clr;

   assign entry = sum_to_entry(s_q, ui_in[5:0]);
   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));

   always_comb begin
      // A pop is only honoured in the data view; in the status view the
      // same pop event clears the sticky bits instead.
      do_pop  = pop_ev & ~ui_in[7] & ~empty;
      do_clr  = pop_ev & ui_in[7];
      // When full, a push still goes through if a pop frees a slot.
      do_push = cap_ev & (~full | do_pop);

      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

      count_d = count_q;
      if (do_push && !do_pop)
         count_d = count_q + 1'b1;
      else if (do_pop && !do_push)
         count_d = count_q - 1'b1;

      // Setting wins over a clear in the same cycle.
      ovf_d      = (ovf_q & ~do_clr) | (cap_ev & full & ~do_pop);
      err_seen_d = (err_seen_q & ~do_clr) | (do_push & entry[6]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         err_seen_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         err_seen_q <= err_seen_d;
      end
   end

   // Storage is data only; stale contents are masked by the valid logic.
   always_ff @(posedge clk) begin
      if (do_push)
         mem_q[wr_ptr_q] <= entry;
   end

   // ---------------- output view ----------------
   logic [6:0] head;
   assign head = empty ? 7'd0 : mem_q[rd_ptr_q];

   always_comb begin
      if (ui_in[7])
         uo_out = {~empty, err_seen_q, ovf_q, full, 4'(count_q)};
      else
         uo_out = {~empty, head};
   end

endmodule

// File: tb/tb_tt_um_nithin574_sum_rx.sv
module tb_tt_um_nithin574_sum_rx;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int n_vec = 0;
   int n_err = 0;

   logic [6:0] sbq [$];
   logic       ovf_m = 1'b0;
   logic       err_m = 1'b0;

   tt_um_nithin574_sum_rx #(.DEPTH(DEPTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .ena    (ena),
      .ui_in  (ui_in),
      .uio_in (uio_in),
      .uo_out (uo_out),
      .uio_out(uio_out),
      .uio_oe (uio_oe)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] model_entry(input logic [5:0] a, input logic [6:0] s);
      logic [7:0] d;
      d = {1'b0, s} - {2'b00, a};
      return {d[7] | d[6], d[5:0]};
   endfunction

   function automatic logic [7:0] exp_data();
      return (sbq.size() != 0) ? {1'b1, sbq[0]} : 8'h00;
   endfunction

   function automatic logic [7:0] exp_status();
      return {sbq.size() != 0, err_m, ovf_m, sbq.size() == DEPTH, 4'(sbq.size())};
   endfunction

   task automatic model_push(input logic [5:0] a, input logic [6:0] s);
      logic [6:0] e;
      e = model_entry(a, s);
      if (sbq.size() < DEPTH) begin
         sbq.push_back(e);
         if (e[6]) err_m = 1'b1;
      end else begin
         ovf_m = 1'b1;
      end
   endtask

   task automatic check_data(input string tag);
      ui_in[7] = 1'b0;
      #1;
      check(tag, uo_out, exp_data());
   endtask

   task automatic check_status(input string tag);
      ui_in[7] = 1'b1;
      #1;
      check(tag, uo_out, exp_status());
      ui_in[7] = 1'b0;
      #1;
   endtask

   task automatic capture(input logic [5:0] a, input logic [6:0] s);
      ui_in[5:0]  = a;
      uio_in[6:0] = s;
      uio_in[7]   = 1'b1;
      tick(2);
      model_push(a, s);
      uio_in[7] = 1'b0;
      tick(1);
   endtask

   task automatic pop_data(input string tag);
      check_data(tag);
      ui_in[7] = 1'b0;
      ui_in[6] = 1'b1;
      tick(2);
      if (sbq.size() != 0) void'(sbq.pop_front());
      ui_in[6] = 1'b0;
      tick(1);
   endtask

   task automatic clear_sticky();
      ui_in[7] = 1'b1;
      ui_in[6] = 1'b1;
      tick(2);
      ovf_m = 1'b0;
      err_m = 1'b0;
      ui_in[6] = 1'b0;
      tick(1);
      ui_in[7] = 1'b0;
      #1;
   endtask

   initial begin
      rst    = 1'b1;
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      tick(3);
      rst = 1'b0;
      tick(1);

      // Reset state
      check("rst_data", uo_out, 8'h00);
      check_status("rst_status");
      ui_in[7] = 1'b1; #1;
      check("rst_status_const", uo_out, 8'h00);
      ui_in[7] = 1'b0; #1;

      // Single capture with exact latency
      ui_in[5:0]  = 6'd10;
      uio_in[6:0] = 7'd25;
      uio_in[7]   = 1'b1;
      tick(1);
      check("lat_1clk", uo_out, 8'h00);
      tick(1);
      model_push(6'd10, 7'd25);
      check("lat_2clk", uo_out, 8'h8F);
      check_data("lat_2clk_model");
      uio_in[7] = 1'b0;
      tick(1);
      pop_data("single_pop");
      check_data("single_empty");

      // Error case
      capture(6'd40, 7'd20);
      check("err_data", uo_out, 8'hEC);
      check_status("err_status");
      pop_data("err_pop");
      clear_sticky();
      check_status("err_cleared");

      // Fill and overflow
      for (int i = 1; i <= 5; i++) capture(6'd0, 7'(i));
      check_status("fill_status");
      ui_in[7] = 1'b1; #1;
      check("fill_status_const", uo_out, 8'hB4);
      ui_in[7] = 1'b0; #1;
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("fill_head%0d_const", i), uo_out, 8'h80 | 8'(i));
         pop_data($sformatf("fill_pop%0d", i));
      end
      check("fill_drained", uo_out, 8'h00);
      check_status("fill_drained_status");
      clear_sticky();

      // Push and pop together while full
      for (int i = 11; i <= 14; i++) capture(6'd1, 7'(i));
      check_status("full_before");
      ui_in[5:0]  = 6'd0;
      uio_in[6:0] = 7'd20;
      uio_in[7]   = 1'b1;
      ui_in[6]    = 1'b1;
      tick(2);
      void'(sbq.pop_front());
      model_push(6'd0, 7'd20);
      uio_in[7] = 1'b0;
      ui_in[6]  = 1'b0;
      tick(1);
      check_status("full_pushpop_status");
      ui_in[7] = 1'b1; #1;
      check("full_pushpop_const", uo_out, 8'h94);
      ui_in[7] = 1'b0; #1;
      check("full_head_const", uo_out, 8'h8B);
      for (int i = 0; i < 4; i++) pop_data($sformatf("full_drain%0d", i));
      check_data("full_drained");

      // Push and pop together while empty
      ui_in[5:0]  = 6'd5;
      uio_in[6:0] = 7'd9;
      uio_in[7]   = 1'b1;
      ui_in[6]    = 1'b1;
      tick(2);
      model_push(6'd5, 7'd9);
      uio_in[7] = 1'b0;
      ui_in[6]  = 1'b0;
      tick(1);
      check_status("empty_pushpop_status");
      check("empty_pushpop_data", uo_out, 8'h84);
      pop_data("empty_pushpop_pop");

      // Strobe held high for 10 clk, then sticky clear via status pop
      ui_in[5:0]  = 6'd20;
      uio_in[6:0] = 7'd5;
      uio_in[7]   = 1'b1;
      tick(2);
      model_push(6'd20, 7'd5);
      tick(8);
      uio_in[7] = 1'b0;
      tick(1);
      check_status("held_status");
      check("held_data", uo_out, 8'hF1);
      for (int i = 0; i < 4; i++) capture(6'd0, 7'(30 + i));
      check_status("held_ovf_status");
      clear_sticky();
      check_status("held_cleared_status");
      ui_in[7] = 1'b1; #1;
      check("held_cleared_const", uo_out, 8'h94);
      ui_in[7] = 1'b0; #1;
      for (int i = 0; i < 4; i++) pop_data($sformatf("held_drain%0d", i));

      // Reset mid-operation with strobe held high through release
      for (int i = 0; i < 3; i++) capture(6'd2, 7'(40 + i));
      check_status("pre_rst_status");
      ui_in[5:0]  = 6'd1;
      uio_in[6:0] = 7'd50;
      uio_in[7]   = 1'b1;
      rst         = 1'b1;
      tick(2);
      rst = 1'b0;
      sbq.delete();
      ovf_m = 1'b0;
      err_m = 1'b0;
      tick(1);
      check_data("post_rst_data");
      check_status("post_rst_status");
      tick(5);
      check("post_rst_held", uo_out, 8'h00);
      check_status("post_rst_held_status");
      uio_in[7] = 1'b0;
      tick(1);
      capture(6'd1, 7'd50);
      check_data("post_rst_capture");
      check_status("post_rst_capture_status");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
